// File: rtl/voice_allocator_pkg.sv
// rtl/voice_allocator_pkg.sv - shared widths and FSM encoding for the voice allocator
// Contents: VOICES, V_WIDTH, MIDI_W and the allocator FSM state type.
package voice_allocator_pkg;
    localparam int VOICES  = 8;
    localparam int V_WIDTH = 3;
    localparam int MIDI_W  = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_RETRIG = 3'd3,
        ST_SUSREL = 3'd4
    } state_e;
endpackage

// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - note event handshake bundle
// Signals: ev_valid/ev_ready handshake, ev_note_on, ev_key, ev_vel.
// master drives the event, slave (the allocator) returns ev_ready.
interface voice_allocator_if;
    import voice_allocator_pkg::*;

    logic              ev_valid;
    logic              ev_ready;
    logic              ev_note_on;
    logic [MIDI_W-1:0] ev_key;
    logic [MIDI_W-1:0] ev_vel;

    modport master (output ev_valid, output ev_note_on, output ev_key, output ev_vel,
                    input  ev_ready);
    modport slave  (input  ev_valid, input  ev_note_on, input  ev_key, input  ev_vel,
                    output ev_ready);
endinterface

// File: rtl/voice_age_lru.sv
// rtl/voice_age_lru.sv - per-voice age tracking for least-recently-used stealing
// Ports: clk_i, rst_ni (async active-low), touch_i/idx_i (mark voice idx_i newest),
//        oldest_idx_o (voice whose age is VOICES-1).
module voice_age_lru
    import voice_allocator_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               touch_i,
    input  logic [V_WIDTH-1:0] idx_i,
    output logic [V_WIDTH-1:0] oldest_idx_o
);
    logic [V_WIDTH-1:0] age_q [VOICES];
    logic [V_WIDTH-1:0] age_d [VOICES];
    logic [V_WIDTH-1:0] old_age;

    // Touched voice becomes 0; only voices younger than it age by one,
    // so the ages remain a permutation of 0..VOICES-1.
    always_comb begin
        old_age = age_q[idx_i];
        for (int i = 0; i < VOICES; i++) begin
            age_d[i] = age_q[i];
            if (touch_i) begin
                if (V_WIDTH'(i) == idx_i) begin
                    age_d[i] = '0;
                end else if (age_q[i] < old_age) begin
                    age_d[i] = age_q[i] + V_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        oldest_idx_o = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (age_q[i] == V_WIDTH'(VOICES - 1)) begin
                oldest_idx_o = V_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < VOICES; i++) begin
                age_q[i] <= V_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - maps MIDI note events onto voice gates and strobes
// Ports: OSC_CLK, reset_reg_N (async active-low), ev (event handshake, slave),
//        sustain, all_notes_off, voice_free in; keys_on, note_on, cur_key_adr,
//        cur_key_val, cur_vel_on, cur_vel_off out.
module voice_allocator
    import voice_allocator_pkg::*;
(
    input  logic               OSC_CLK,
    input  logic               reset_reg_N,
    voice_allocator_if.slave   ev,
    input  logic               sustain,
    input  logic               all_notes_off,
    input  logic [VOICES-1:0]  voice_free,
    output logic [VOICES-1:0]  keys_on,
    output logic               note_on,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [7:0]         cur_key_val,
    output logic [7:0]         cur_vel_on,
    output logic [7:0]         cur_vel_off
);
    state_e             state_q, state_d;
    logic [V_WIDTH-1:0] scan_idx_q, scan_idx_d;
    logic               match_found_q, match_found_d;
    logic [V_WIDTH-1:0] match_idx_q, match_idx_d;
    logic               free_found_q, free_found_d;
    logic [V_WIDTH-1:0] free_idx_q, free_idx_d;
    logic               ev_on_q, ev_on_d;
    logic [MIDI_W-1:0]  ev_key_q, ev_key_d;
    logic [MIDI_W-1:0]  ev_vel_q, ev_vel_d;
    logic [MIDI_W-1:0]  key_tab_q [VOICES];
    logic [MIDI_W-1:0]  key_tab_d [VOICES];
    logic [VOICES-1:0]  sus_pend_q, sus_pend_d;
    logic               sus_req_q, sus_req_d;
    logic               sus_prev_q;
    logic [V_WIDTH-1:0] tgt_q, tgt_d;
    logic [VOICES-1:0]  keys_on_q, keys_on_d;
    logic               note_on_q, note_on_d;
    logic [V_WIDTH-1:0] cur_adr_q, cur_adr_d;
    logic [7:0]         cur_val_q, cur_val_d;
    logic [7:0]         von_q, von_d;
    logic [7:0]         voff_q, voff_d;

    logic               sus_fall;
    logic               rel_pend;
    logic [V_WIDTH-1:0] tgt;
    logic [V_WIDTH-1:0] oldest_idx;
    logic               lru_touch;

    // A pedal release seen this very cycle already blocks the handshake,
    // so the release always precedes an event offered alongside it.
    assign sus_fall    = sus_prev_q & ~sustain;
    assign rel_pend    = sus_req_q | sus_fall;
    assign ev.ev_ready = (state_q == ST_IDLE) && !rel_pend;

    assign tgt = match_found_q ? match_idx_q :
                 free_found_q  ? free_idx_q  : oldest_idx;

    voice_age_lru u_lru (
        .clk_i        (OSC_CLK),
        .rst_ni       (reset_reg_N),
        .touch_i      (lru_touch),
        .idx_i        (tgt),
        .oldest_idx_o (oldest_idx)
    );

    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        ev_on_d       = ev_on_q;
        ev_key_d      = ev_key_q;
        ev_vel_d      = ev_vel_q;
        key_tab_d     = key_tab_q;
        sus_pend_d    = sus_pend_q;
        sus_req_d     = sus_req_q | sus_fall;
        tgt_d         = tgt_q;
        keys_on_d     = keys_on_q;
        note_on_d     = 1'b0;
        cur_adr_d     = cur_adr_q;
        cur_val_d     = cur_val_q;
        von_d         = von_q;
        voff_d        = voff_q;
        lru_touch     = 1'b0;

        if (all_notes_off) begin
            // In-flight event is abandoned; ages and key table survive.
            keys_on_d  = '0;
            sus_pend_d = '0;
            sus_req_d  = 1'b0;
            state_d    = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rel_pend) begin
                        state_d = ST_SUSREL;
                    end else if (ev.ev_valid) begin
                        ev_on_d       = ev.ev_note_on && (ev.ev_vel != '0);
                        ev_key_d      = ev.ev_key;
                        ev_vel_d      = ev.ev_vel;
                        scan_idx_d    = '0;
                        match_found_d = 1'b0;
                        free_found_d  = 1'b0;
                        state_d       = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // A voice still sounding its release counts as holding its key.
                    if (!match_found_q && (key_tab_q[scan_idx_q] == ev_key_q) &&
                        (keys_on_q[scan_idx_q] || !voice_free[scan_idx_q])) begin
                        match_found_d = 1'b1;
                        match_idx_d   = scan_idx_q;
                    end
                    if (!free_found_q && voice_free[scan_idx_q] && !keys_on_q[scan_idx_q]) begin
                        free_found_d = 1'b1;
                        free_idx_d   = scan_idx_q;
                    end
                    if (scan_idx_q == V_WIDTH'(VOICES - 1)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        scan_idx_d = scan_idx_q + V_WIDTH'(1);
                    end
                end
                ST_COMMIT: begin
                    state_d = ST_IDLE;
                    tgt_d   = tgt;
                    if (ev_on_q) begin
                        key_tab_d[tgt]  = ev_key_q;
                        cur_adr_d       = tgt;
                        cur_val_d       = {1'b0, ev_key_q};
                        von_d           = {1'b0, ev_vel_q};
                        sus_pend_d[tgt] = 1'b0;
                        lru_touch       = 1'b1;
                        if (keys_on_q[tgt]) begin
                            // Drop the gate for one cycle so the envelope restarts.
                            keys_on_d[tgt] = 1'b0;
                            state_d        = ST_RETRIG;
                        end else begin
                            keys_on_d[tgt] = 1'b1;
                            note_on_d      = 1'b1;
                        end
                    end else if (match_found_q) begin
                        cur_adr_d = match_idx_q;
                        cur_val_d = {1'b0, ev_key_q};
                        voff_d    = {1'b0, ev_vel_q};
                        if (sustain) begin
                            sus_pend_d[match_idx_q] = 1'b1;
                        end else begin
                            keys_on_d[match_idx_q] = 1'b0;
                        end
                    end
                end
                ST_RETRIG: begin
                    keys_on_d[tgt_q] = 1'b1;
                    note_on_d        = 1'b1;
                    state_d          = ST_IDLE;
                end
                ST_SUSREL: begin
                    keys_on_d  = keys_on_q & ~sus_pend_q;
                    sus_pend_d = '0;
                    sus_req_d  = sus_fall;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q       <= ST_IDLE;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            ev_on_q       <= 1'b0;
            ev_key_q      <= '0;
            ev_vel_q      <= '0;
            for (int i = 0; i < VOICES; i++) begin
                key_tab_q[i] <= '0;
            end
            sus_pend_q    <= '0;
            sus_req_q     <= 1'b0;
            sus_prev_q    <= 1'b0;
            tgt_q         <= '0;
            keys_on_q     <= '0;
            note_on_q     <= 1'b0;
            cur_adr_q     <= '0;
            cur_val_q     <= '0;
            von_q         <= '0;
            voff_q        <= '0;
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            ev_on_q       <= ev_on_d;
            ev_key_q      <= ev_key_d;
            ev_vel_q      <= ev_vel_d;
            for (int i = 0; i < VOICES; i++) begin
                key_tab_q[i] <= key_tab_d[i];
            end
            sus_pend_q    <= sus_pend_d;
            sus_req_q     <= sus_req_d;
            sus_prev_q    <= sustain;
            tgt_q         <= tgt_d;
            keys_on_q     <= keys_on_d;
            note_on_q     <= note_on_d;
            cur_adr_q     <= cur_adr_d;
            cur_val_q     <= cur_val_d;
            von_q         <= von_d;
            voff_q        <= voff_d;
        end
    end

    assign keys_on     = keys_on_q;
    assign note_on     = note_on_q;
    assign cur_key_adr = cur_adr_q;
    assign cur_key_val = cur_val_q;
    assign cur_vel_on  = von_q;
    assign cur_vel_off = voff_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed self-checking bench for voice_allocator
module tb_voice_allocator;
    import voice_allocator_pkg::*;

    logic               OSC_CLK = 1'b0;
    logic               reset_reg_N;
    logic               sustain;
    logic               all_notes_off;
    logic [VOICES-1:0]  voice_free;
    logic [VOICES-1:0]  keys_on;
    logic               note_on;
    logic [V_WIDTH-1:0] cur_key_adr;
    logic [7:0]         cur_key_val;
    logic [7:0]         cur_vel_on;
    logic [7:0]         cur_vel_off;

    int total = 0;
    int bad   = 0;

    voice_allocator_if evif();

    voice_allocator dut (
        .OSC_CLK       (OSC_CLK),
        .reset_reg_N   (reset_reg_N),
        .ev            (evif),
        .sustain       (sustain),
        .all_notes_off (all_notes_off),
        .voice_free    (voice_free),
        .keys_on       (keys_on),
        .note_on       (note_on),
        .cur_key_adr   (cur_key_adr),
        .cur_key_val   (cur_key_val),
        .cur_vel_on    (cur_vel_on),
        .cur_vel_off   (cur_vel_off)
    );

    always #5 OSC_CLK = ~OSC_CLK;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    typedef struct {
        bit on;
        int key;
        int vel;
        int exp_keys;
        int exp_k9;
        int exp_adr;
        int exp_val;
        int exp_von;
        int exp_voff;
        int exp_pulses;
        int exp_lat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge OSC_CLK);
        reset_reg_N = 1'b0;
        repeat (2) @(negedge OSC_CLK);
        reset_reg_N = 1'b1;
        #1;
        chk("rst_keys_on", int'(keys_on), 0);
        chk("rst_note_on", int'(note_on), 0);
        chk("rst_adr", int'(cur_key_adr), 0);
        chk("rst_val", int'(cur_key_val), 0);
        chk("rst_von", int'(cur_vel_on), 0);
        chk("rst_voff", int'(cur_vel_off), 0);
        chk("rst_ready", int'(evif.ev_ready), 1);
    endtask

    // Counts cycles after the handshake edge until the allocator is idle again.
    task automatic finish_event(output int lat, output int pulses, output int keys9, output int ok);
        lat = 0; pulses = 0; keys9 = -1; ok = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge OSC_CLK);
            #1;
            if (c == VOICES + 1) keys9 = int'(keys_on);
            if (note_on) begin
                pulses++;
                if (lat == 0) lat = c;
            end
            if (evif.ev_ready && c >= VOICES + 1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic send_event(input bit on, input int key, input int vel,
                              output int lat, output int pulses, output int keys9, output int ok);
        int w;
        @(negedge OSC_CLK);
        evif.ev_valid   = 1'b1;
        evif.ev_note_on = on;
        evif.ev_key     = 7'(key);
        evif.ev_vel     = 7'(vel);
        w = 0;
        while (!evif.ev_ready && w < 20) begin
            @(negedge OSC_CLK);
            w++;
        end
        if (!evif.ev_ready) begin
            evif.ev_valid = 1'b0;
            lat = 0; pulses = 0; keys9 = -1; ok = 0;
        end else begin
            @(posedge OSC_CLK);
            #1;
            evif.ev_valid = 1'b0;
            finish_event(lat, pulses, keys9, ok);
        end
    endtask

    initial begin
        int lat, pulses, k9, ok, cnt;

        reset_reg_N     = 1'b1;
        sustain         = 1'b0;
        all_notes_off   = 1'b0;
        voice_free      = '1;
        evif.ev_valid   = 1'b0;
        evif.ev_note_on = 1'b0;
        evif.ev_key     = '0;
        evif.ev_vel     = '0;

        //              on key vel keys k9   adr val von voff pul lat
        vecs[0] = '{1'b1, 60, 100, 'h01, 'h01, 0, 60, 100, 0,  1, 9};
        vecs[1] = '{1'b1, 62,  90, 'h03, 'h03, 1, 62,  90, 0,  1, 9};
        vecs[2] = '{1'b1, 64,  80, 'h07, 'h07, 2, 64,  80, 0,  1, 9};
        vecs[3] = '{1'b0, 62,  40, 'h05, 'h05, 1, 62,  80, 40, 0, 0};
        vecs[4] = '{1'b1, 64,   0, 'h01, 'h01, 2, 64,  80, 0,  0, 0};
        vecs[5] = '{1'b1, 60,  50, 'h01, 'h00, 0, 60,  50, 0,  1, 10};
        vecs[6] = '{1'b0, 99,  10, 'h01, 'h01, 0, 60,  50, 0,  0, 0};

        do_reset();

        for (int i = 0; i < 7; i++) begin
            send_event(vecs[i].on, vecs[i].key, vecs[i].vel, lat, pulses, k9, ok);
            chk($sformatf("v%0d_done", i), ok, 1);
            chk($sformatf("v%0d_keys", i), int'(keys_on), vecs[i].exp_keys);
            chk($sformatf("v%0d_keys_at9", i), k9, vecs[i].exp_k9);
            chk($sformatf("v%0d_adr", i), int'(cur_key_adr), vecs[i].exp_adr);
            chk($sformatf("v%0d_val", i), int'(cur_key_val), vecs[i].exp_val);
            chk($sformatf("v%0d_von", i), int'(cur_vel_on), vecs[i].exp_von);
            chk($sformatf("v%0d_voff", i), int'(cur_vel_off), vecs[i].exp_voff);
            chk($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
        end

        // Fill every voice, then steal twice in LRU order.
        do_reset();
        voice_free = '1;
        for (int i = 0; i < VOICES; i++) begin
            send_event(1'b1, 60 + i, 100, lat, pulses, k9, ok);
            chk($sformatf("fill%0d_keys", i), int'(keys_on), (1 << (i + 1)) - 1);
            chk($sformatf("fill%0d_adr", i), int'(cur_key_adr), i);
        end
        voice_free = '0;
        send_event(1'b1, 70, 90, lat, pulses, k9, ok);
        chk("steal0_gap", k9, 'hfe);
        chk("steal0_lat", lat, 10);
        chk("steal0_pulses", pulses, 1);
        chk("steal0_keys", int'(keys_on), 'hff);
        chk("steal0_adr", int'(cur_key_adr), 0);
        chk("steal0_val", int'(cur_key_val), 70);
        send_event(1'b1, 71, 90, lat, pulses, k9, ok);
        chk("steal1_gap", k9, 'hfd);
        chk("steal1_lat", lat, 10);
        chk("steal1_adr", int'(cur_key_adr), 1);
        chk("steal1_val", int'(cur_key_val), 71);

        // Sustain hold, then pedal release racing a pending event.
        do_reset();
        voice_free = '1;
        @(negedge OSC_CLK);
        sustain = 1'b1;
        send_event(1'b1, 60, 100, lat, pulses, k9, ok);
        chk("sus_on_keys", int'(keys_on), 'h01);
        send_event(1'b0, 60, 30, lat, pulses, k9, ok);
        chk("sus_off_keys", int'(keys_on), 'h01);
        chk("sus_off_voff", int'(cur_vel_off), 30);
        chk("sus_off_pulses", pulses, 0);
        @(negedge OSC_CLK);
        sustain         = 1'b0;
        evif.ev_valid   = 1'b1;
        evif.ev_note_on = 1'b1;
        evif.ev_key     = 7'd61;
        evif.ev_vel     = 7'd70;
        #1;
        chk("susrel_ready_blocked", int'(evif.ev_ready), 0);
        @(posedge OSC_CLK);
        #1;
        chk("susrel_keys_held", int'(keys_on), 'h01);
        chk("susrel_ready_in_rel", int'(evif.ev_ready), 0);
        @(posedge OSC_CLK);
        #1;
        chk("susrel_keys_released", int'(keys_on), 'h00);
        chk("susrel_ready_back", int'(evif.ev_ready), 1);
        @(posedge OSC_CLK);
        #1;
        evif.ev_valid = 1'b0;
        finish_event(lat, pulses, k9, ok);
        chk("after_rel_lat", lat, 9);
        chk("after_rel_keys", int'(keys_on), 'h01);
        chk("after_rel_val", int'(cur_key_val), 61);

        // all_notes_off in the middle of a scan.
        do_reset();
        voice_free = '1;
        send_event(1'b1, 60, 100, lat, pulses, k9, ok);
        send_event(1'b1, 62, 100, lat, pulses, k9, ok);
        send_event(1'b1, 64, 100, lat, pulses, k9, ok);
        chk("ano_pre_keys", int'(keys_on), 'h07);
        @(negedge OSC_CLK);
        evif.ev_valid   = 1'b1;
        evif.ev_note_on = 1'b1;
        evif.ev_key     = 7'd66;
        evif.ev_vel     = 7'd90;
        @(posedge OSC_CLK);
        #1;
        evif.ev_valid = 1'b0;
        repeat (3) @(posedge OSC_CLK);
        @(negedge OSC_CLK);
        all_notes_off = 1'b1;
        @(posedge OSC_CLK);
        #1;
        all_notes_off = 1'b0;
        chk("ano_keys", int'(keys_on), 0);
        chk("ano_ready", int'(evif.ev_ready), 1);
        chk("ano_adr_kept", int'(cur_key_adr), 2);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge OSC_CLK);
            #1;
            if (note_on) cnt++;
        end
        chk("ano_no_pulse", cnt, 0);
        send_event(1'b1, 66, 90, lat, pulses, k9, ok);
        chk("ano_next_keys", int'(keys_on), 'h01);
        chk("ano_next_val", int'(cur_key_val), 66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
